id_operand_unit: RTL and testbench

- Parametrised operand-supply and hazard block for the ID stage; it replaces the fixed 2-read regfile and the single load-use compare.
- Holds the architectural register file and resolves each read port against NFWD prioritised forwarding buses.
- Keeps a per-register scoreboard of long-latency writes (mult/div, multi-cycle loads).
- Raises a single stall request to ctrl whenever any enabled operand is not yet obtainable.

---
 rtl/id_operand_unit_pkg.sv | 22 ++
 rtl/id_operand_unit_if.sv | 40 ++++
 rtl/id_operand_unit_regfile.sv | 35 +++
 rtl/id_operand_unit.sv | 109 ++++++++++
 tb/tb_id_operand_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_operand_unit_pkg.sv
// Shared constants and types for the ID-stage operand unit.
// Bus field layout for fwd_bus and the stop encoding for stall_in.
package id_operand_unit_pkg;

  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int NRD_DEF  = 2;
  localparam int NFWD_DEF = 3;
  localparam int LW_DEF   = 4;

  localparam int FWD_WD       = 1 + AW_DEF + DW_DEF;
  localparam int FWD_WDATA_LO = 0;
  localparam int FWD_WADDR_LO = DW_DEF;
  localparam int FWD_WE_BIT   = DW_DEF + AW_DEF;

  typedef enum logic {
    NO_STOP = 1'b0,
    STOP    = 1'b1
  } stop_e;

endpackage

// File: rtl/id_operand_unit_if.sv
// Operand-unit bundle: read ports, forwarding, writeback, issue, stall.
// master drives the request side, slave is the operand unit.
interface id_operand_unit_if #(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NRD  = 2,
  parameter int NFWD = 3,
  parameter int LW   = 4
);
  logic [NRD-1:0]             rd_en;
  logic [NRD*AW-1:0]          raddr;
  logic [NRD*DW-1:0]          rdata;
  logic [NFWD*(1+AW+DW)-1:0]  fwd_bus;
  logic [NFWD-1:0]            fwd_ready;
  logic                       wb_we;
  logic [AW-1:0]              wb_waddr;
  logic [DW-1:0]              wb_wdata;
  logic                       issue_valid;
  logic [AW-1:0]              issue_waddr;
  logic [LW-1:0]              issue_lat;
  logic                       stall_in;
  logic                       stallreq;
  logic [NRD-1:0]             hazard_port;

  modport master (
    output rd_en, raddr, fwd_bus, fwd_ready,
    output wb_we, wb_waddr, wb_wdata,
    output issue_valid, issue_waddr, issue_lat,
    output stall_in,
    input  rdata, stallreq, hazard_port
  );

  modport slave (
    input  rd_en, raddr, fwd_bus, fwd_ready,
    input  wb_we, wb_waddr, wb_wdata,
    input  issue_valid, issue_waddr, issue_lat,
    input  stall_in,
    output rdata, stallreq, hazard_port
  );
endinterface

// File: rtl/id_operand_unit_regfile.sv
// Multi-read-port register file, one write port, r0 hardwired to zero.
// No internal write-to-read bypass; the top level supplies that.
module id_regfile_mp #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NRD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata
);

  logic [DW-1:0] mem [NREG];

  // write port; reset wipes the whole array
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[p*AW +: AW];
    assign rdata[p*DW +: DW] = (ra == '0) ? '0 : mem[ra];
  end

endmodule

// File: rtl/id_operand_unit.sv
// ID-stage operand supply: regfile, prioritised forwarding,
// long-latency scoreboard and the stall request to ctrl.
module id_operand_unit
  import id_operand_unit_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int NRD  = NRD_DEF,
  parameter int NFWD = NFWD_DEF,
  parameter int LW   = LW_DEF
) (
  input logic clk,
  input logic rst,
  id_operand_unit_if.slave io
);

  localparam int FW    = 1 + AW + DW;
  localparam int WD_LO = 0;
  localparam int WA_LO = DW;
  localparam int WE_B  = DW + AW;

  logic [NRD*DW-1:0] rf_rdata;
  logic [NRD*DW-1:0] rd;
  logic [NRD-1:0]    hz;
  logic [NFWD-1:0]   f_we;
  logic [AW-1:0]     f_wa [NFWD];
  logic [DW-1:0]     f_wd [NFWD];
  logic [LW-1:0]     cnt [NREG];
  logic              waw;
  logic              stall;
  logic              take;

  id_regfile_mp #(
    .NREG (NREG),
    .AW   (AW),
    .DW   (DW),
    .NRD  (NRD)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (io.wb_we),
    .waddr (io.wb_waddr),
    .wdata (io.wb_wdata),
    .raddr (io.raddr),
    .rdata (rf_rdata)
  );

  for (genvar i = 0; i < NFWD; i++) begin : g_fwd
    assign f_we[i] = io.fwd_bus[i*FW + WE_B];
    assign f_wa[i] = io.fwd_bus[i*FW + WA_LO +: AW];
    assign f_wd[i] = io.fwd_bus[i*FW + WD_LO +: DW];
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [AW-1:0] ra;
    logic [DW-1:0] d;
    logic          pend;
    logic          found;
    logic          busy;

    assign ra = io.raddr[p*AW +: AW];

    // youngest matching bus wins, then wb bypass, then the array
    always_comb begin
      d     = rf_rdata[p*DW +: DW];
      pend  = 1'b0;
      found = 1'b0;
      if (ra == '0) begin
        d = '0;
      end else begin
        for (int i = 0; i < NFWD; i++) begin
          if (!found && f_we[i] && f_wa[i] == ra) begin
            found = 1'b1;
            pend  = !io.fwd_ready[i];
            d     = io.fwd_ready[i] ? f_wd[i] : '0;
          end
        end
        if (!found && io.wb_we && io.wb_waddr == ra) d = io.wb_wdata;
      end
    end

    assign busy = (ra != '0) && (cnt[ra] != '0);
    assign rd[p*DW +: DW] = d;
    assign hz[p] = io.rd_en[p] & (pend | busy);
  end

  assign waw   = io.issue_valid && (cnt[io.issue_waddr] != '0);
  assign stall = (|hz) | waw;
  assign take  = io.issue_valid && (io.stall_in == NO_STOP) &&
                 !stall && (io.issue_waddr != '0);

  assign io.rdata       = rd;
  assign io.hazard_port = hz;
  assign io.stallreq    = stall;

  // counters free-run down to zero; an accepted issue reloads its entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (take && io.issue_waddr == AW'(r)) cnt[r] <= io.issue_lat;
        else if (cnt[r] != '0) cnt[r] <= cnt[r] - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_operand_unit.sv
// Randomised + directed bench for id_operand_unit.
// Reference model pushes expectations; a monitor pops and compares.
module tb_id_operand_unit;
  import id_operand_unit_pkg::*;

  localparam int NREG = NREG_DEF;
  localparam int AW   = AW_DEF;
  localparam int DW   = DW_DEF;
  localparam int NRD  = NRD_DEF;
  localparam int NFWD = NFWD_DEF;
  localparam int LW   = LW_DEF;
  localparam int FW   = 1 + AW + DW;

  typedef struct {
    int               id;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0]   haz;
    logic             stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  id_operand_unit_if #(
    .AW(AW), .DW(DW), .NRD(NRD), .NFWD(NFWD), .LW(LW)
  ) ifc ();

  id_operand_unit #(
    .NREG(NREG), .AW(AW), .DW(DW), .NRD(NRD), .NFWD(NFWD), .LW(LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc.slave)
  );

  always #5 clk = ~clk;

  // stimulus in readable form
  logic          ren [NRD];
  logic [AW-1:0] ra  [NRD];
  logic          fwe [NFWD];
  logic [AW-1:0] fwa [NFWD];
  logic [DW-1:0] fwd [NFWD];
  logic          frdy [NFWD];
  logic          wwe;
  logic [AW-1:0] wwa;
  logic [DW-1:0] wwd;
  logic          iv;
  logic [AW-1:0] iw;
  logic [LW-1:0] il;
  logic          sin;

  // reference state
  logic [DW-1:0] m_reg [NREG];
  int            m_cnt [NREG];

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_id  = 0;

  task automatic idle();
    for (int p = 0; p < NRD; p++) begin ren[p] = 0; ra[p] = '0; end
    for (int i = 0; i < NFWD; i++) begin
      fwe[i] = 0; fwa[i] = '0; fwd[i] = '0; frdy[i] = 1;
    end
    wwe = 0; wwa = '0; wwd = '0;
    iv = 0; iw = '0; il = '0; sin = 0; rst = 0;
  endtask

  task automatic drive();
    for (int p = 0; p < NRD; p++) begin
      ifc.rd_en[p] = ren[p];
      ifc.raddr[p*AW +: AW] = ra[p];
    end
    for (int i = 0; i < NFWD; i++) begin
      ifc.fwd_bus[i*FW +: FW] = {fwe[i], fwa[i], fwd[i]};
      ifc.fwd_ready[i] = frdy[i];
    end
    ifc.wb_we = wwe; ifc.wb_waddr = wwa; ifc.wb_wdata = wwd;
    ifc.issue_valid = iv; ifc.issue_waddr = iw; ifc.issue_lat = il;
    ifc.stall_in = sin;
  endtask

  // apply current stimulus for one cycle; chk=0 skips the expectation
  task automatic step(input bit chk);
    exp_t e;
    logic stall;
    drive();
    e.id = n_id; n_id++;
    e.rdata = '0; e.haz = '0;
    for (int p = 0; p < NRD; p++) begin
      logic [DW-1:0] d;
      bit pend, hit;
      int a;
      a = int'(ra[p]); d = '0; pend = 0; hit = 0;
      if (a != 0) begin
        for (int i = 0; i < NFWD; i++) begin
          if (!hit && fwe[i] && int'(fwa[i]) == a) begin
            hit = 1;
            if (frdy[i]) d = fwd[i]; else pend = 1;
          end
        end
        if (!hit) d = (wwe && int'(wwa) == a) ? wwd : m_reg[a];
      end
      e.rdata[p*DW +: DW] = d;
      e.haz[p] = ren[p] && (pend || (a != 0 && m_cnt[a] > 0));
    end
    stall = (e.haz != '0) || (iv && m_cnt[int'(iw)] > 0);
    e.stall = stall;
    if (chk) q.push_back(e);
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin m_reg[r] = '0; m_cnt[r] = 0; end
    end else begin
      if (wwe && wwa != '0) m_reg[int'(wwa)] = wwd;
      for (int r = 0; r < NREG; r++) if (m_cnt[r] > 0) m_cnt[r]--;
      if (iv && !sin && !stall && iw != '0) m_cnt[int'(iw)] = int'(il);
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: outputs are combinational, so one expectation per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (ifc.rdata !== e.rdata || ifc.hazard_port !== e.haz ||
            ifc.stallreq !== e.stall) begin
          n_err++;
          $display("FAIL vec%0d rdata=%h/%h haz=%b/%b stall=%b/%b (got/exp)",
                   e.id, ifc.rdata, e.rdata, ifc.hazard_port, e.haz,
                   ifc.stallreq, e.stall);
        end
      end
    end
  end

  initial begin
    for (int r = 0; r < NREG; r++) begin m_reg[r] = '0; m_cnt[r] = 0; end
    idle(); rst = 1;
    step(0); step(0);
    idle();

    // reset state, then wb write and read-back
    ren[0] = 1; ren[1] = 1; ra[0] = 5; ra[1] = 5; step(1);
    wwe = 1; wwa = 5; wwd = 32'h1234; step(1);
    idle(); ren[0] = 1; ren[1] = 1; ra[0] = 5; ra[1] = 5; step(1);

    // bus priority
    fwe[0] = 1; fwa[0] = 5; fwd[0] = 32'hAAAA;
    fwe[1] = 1; fwa[1] = 5; fwd[1] = 32'hBBBB; step(1);

    // load still in EX
    idle(); fwe[0] = 1; fwa[0] = 7; fwd[0] = 32'h5555; frdy[0] = 0;
    ren[1] = 1; ra[1] = 7; step(1);
    ren[1] = 0; step(1);

    // long op r9, lat 3, wb in cycle 3
    idle(); iv = 1; iw = 9; il = 3; step(1);
    idle(); ren[0] = 1; ra[0] = 9; step(1); step(1);
    wwe = 1; wwa = 9; wwd = 32'hDEAD; step(1);
    wwe = 0; step(1);

    // WAW on r9 while busy
    idle(); iv = 1; iw = 9; il = 3; step(1);
    idle(); ren[0] = 1; ra[0] = 9; step(1);
    iv = 1; iw = 9; il = 7; step(1);
    iv = 0; step(1); step(1); step(1);

    // issue blocked by stall_in
    idle(); iv = 1; iw = 4; il = 5; sin = 1; step(1);
    idle(); ren[0] = 1; ra[0] = 4; step(1);

    // r0 never written, never stalls
    idle(); wwe = 1; wwa = 0; wwd = 32'hFFFF;
    fwe[0] = 1; fwa[0] = 0; fwd[0] = 32'h77; frdy[0] = 0;
    ren[0] = 1; ren[1] = 1; step(1);
    idle(); ren[0] = 1; ren[1] = 1; step(1);

    // reset drops in-flight long ops
    idle(); iv = 1; iw = 3; il = 5; step(1);
    idle(); ren[0] = 1; ra[0] = 3; step(1);
    rst = 1; step(1);
    rst = 0; step(1);

    // random traffic on a narrow register window
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < NRD; p++) begin
        ren[p] = 1'($urandom_range(0, 3) != 0);
        ra[p]  = AW'($urandom_range(0, 7));
      end
      for (int i = 0; i < NFWD; i++) begin
        fwe[i]  = 1'($urandom_range(0, 2) == 0);
        fwa[i]  = AW'($urandom_range(0, 7));
        fwd[i]  = $urandom;
        frdy[i] = 1'($urandom_range(0, 3) != 0);
      end
      wwe = 1'($urandom_range(0, 1));
      wwa = AW'($urandom_range(0, 7));
      wwd = $urandom;
      iv  = 1'($urandom_range(0, 3) == 0);
      iw  = AW'($urandom_range(0, 7));
      il  = LW'($urandom_range(0, 5));
      sin = 1'($urandom_range(0, 7) == 0);
      rst = 1'($urandom_range(0, 149) == 0);
      step(1);
    end

    idle(); step(1);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
